alu_exec: RTL
=============

# alu_exec

Parametrised RV32IM execute unit, and the successor to the single-cycle integer ALU in the core's execute stage. It decodes opcode/func3/func7 for the full RV32I register-register and register-immediate integer set. It adds the M extension (multiply, divide, remainder) through an iterative datapath behind a valid/ready handshake, so the decode stage can stall on multi-cycle ops.

## Interface
- XLEN, 32: operand/result width; must be a power of two ≥ 8.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- data1  in  XLEN  rs1 value.
- data2  in  XLEN  rs2 value, or sign-extended immediate for opcode 0010011.
- opcode  in  7  instruction opcode.
- func3  in  3  instruction func3.
- func7  in  7  instruction func7.
- flush  in  1  synchronous abort of the in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- illegal  out  1  qualifies result; op was not decodable.

## Operation
- Decode, sampled only on accept (in_valid & in_ready):
  - opcode 0110011, func7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - opcode 0110011, func7 0100000: SUB (func3 000), SRA (func3 101).
  - opcode 0110011, func7 0000001: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - opcode 0010011: same ops as func7=0 R-type, with no SUB. SRAI when func3 101 and func7[5].
  - Anything else: illegal=1, result=0, single-cycle path.
- Shift amount is data2[$clog2(XLEN)-1:0]. SLT/SLTU results are zero-extended 0/1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, on accept of a single-cycle op: go to DONE with the result registered.
  - IDLE, on accept of an M op: go to BUSY with the counter cleared.
  - BUSY: counter increments each cycle. At count XLEN-1, go to DONE with the result registered.
  - DONE: out_valid=1. On out_ready with no accept, go to IDLE. On out_ready with an accept, follow the IDLE accept rules.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from the state and out_ready only.
- Multiply is radix-2 shift-add on XLEN+1-bit signed-extended operands, with a 2·XLEN accumulator. MUL returns the low half; the MULH variants return the high half.
- Divide is restoring. Sign is applied after the magnitude division: quotient negated if operand signs differ, remainder takes the dividend's sign.
- Divide special cases resolve in one cycle (IDLE→DONE, no BUSY):
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0.
- flush:
  - In any state, the unit goes to IDLE next cycle and out_valid drops.
  - flush beats a simultaneous accept; that request is not taken.
- While out_valid=1 and out_ready=0, result and illegal hold stable.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, illegal 0, counter 0. in_ready is therefore 1.
- rst_n low mid-BUSY aborts immediately with the same values. No result is emitted afterwards.
- Latency from accept edge to out_valid:
  - Single-cycle ops, illegal ops and divide special cases: 1 cycle.
  - Other M ops: XLEN+1 cycles (33 at XLEN=32), independent of operand values.
- Throughput: single-cycle ops 1/cycle when out_ready stays high. M ops 1 per XLEN+1 cycles.

## Structure
- alu_pkg holds:
  - opcode constants (OP_R, OP_I);
  - func3 encodings for the base and M ops;
  - func7 constants;
  - the op enum alu_op_e;
  - the state enum alu_state_e.
- One sub-module, muldiv_iter, holds the iterative multiply/divide datapath. Its inputs are start, signedness and op select. Its outputs are done and a XLEN-wide result. The FSM and all single-cycle ops stay in alu_exec.

## Test plan
- ADD 5+7 → 12, one cycle after accept. SUB 3−5 (func7 0100000) → 0xFFFFFFFE. Back-to-back issue with out_ready=1 gives one result per cycle.
- SRA 0x80000000 by 4 → 0xF8000000. SRAI (opcode 0010011, func7[5]=1) → same. SRL → 0x08000000. SLTU 1<0xFFFFFFFF → 1. SLT → 0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH → 0. MUL → 1. out_valid rises exactly 33 cycles after accept, with in_ready=0 throughout BUSY.
- DIV 7/0 → 0xFFFFFFFF and REM 7/0 → 7, both with latency 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. DIV −7/2 → −3, REM → −1.
- Backpressure: out_ready held low 5 cycles in DONE keeps result stable and in_ready low. Then out_ready=1 with in_valid=1 in the same cycle accepts the next op with no bubble.
- flush at BUSY cycle 10 of DIVU → IDLE next cycle, out_valid never rises. rst_n pulsed mid-BUSY → same. opcode 0000000 → illegal=1, result=0, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the RV32IM execute unit: opcodes, func3/func7 fields,
// the decoded operation enum and the control FSM states.
package alu_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_ILLEGAL
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } alu_state_e;

  function automatic logic is_muldiv(input alu_op_e op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_exec_muldiv_iter.sv
// Iterative multiply/divide: radix-2 shift-add multiply and restoring divide,
// XLEN steps per operation. o_done and o_result reflect the final step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_signed_a,
  input  logic            i_signed_b,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  logic            r_busy;
  logic [CW-1:0]   r_count;
  alu_op_e         r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic            r_sub_last;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic            r_neg_q;
  logic            r_neg_r;

  logic [XLEN:0]     w_a_ext;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_last;
  logic [2*XLEN-1:0] w_addend;
  logic [2*XLEN-1:0] w_acc_step;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_rem_step;
  logic [XLEN-1:0]   w_quo_step;

  assign w_a_ext = {i_signed_a & i_a[XLEN-1], i_a};
  assign w_a_mag = (i_signed_a & i_a[XLEN-1]) ? -i_a : i_a;
  assign w_b_mag = (i_signed_b & i_b[XLEN-1]) ? -i_b : i_b;

  // A signed multiplier's top bit carries negative weight, so the last step subtracts.
  assign w_last     = (r_count == CW'(XLEN - 1));
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_step = (w_last & r_sub_last) ? (r_acc - w_addend) : (r_acc + w_addend);

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_rem_step = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_step = {r_quo[XLEN-2:0], ~w_diff[XLEN]};

  assign o_done = r_busy & w_last;

  always_comb begin
    o_result = '0;
    case (r_op)
      ALU_MUL:                        o_result = w_acc_step[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: o_result = w_acc_step[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              o_result = r_neg_q ? -w_quo_step : w_quo_step;
      ALU_REM, ALU_REMU:              o_result = r_neg_r ? -w_rem_step : w_rem_step;
      default:                        o_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_count    <= '0;
      r_op       <= ALU_ADD;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_sub_last <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_count    <= '0;
      r_op       <= i_op;
      r_acc      <= '0;
      r_mcand    <= {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
      r_mplier   <= i_b;
      r_sub_last <= i_signed_b;
      r_rem      <= '0;
      r_quo      <= w_a_mag;
      r_div      <= w_b_mag;
      r_neg_q    <= i_signed_a & i_signed_b & (i_a[XLEN-1] ^ i_b[XLEN-1]);
      r_neg_r    <= i_signed_a & i_a[XLEN-1];
    end else if (r_busy) begin
      r_count  <= r_count + CW'(1);
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_rem    <= w_rem_step;
      r_quo    <= w_quo_step;
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// RV32IM execute unit: single-cycle integer ops plus an iterative M-extension
// datapath, all behind a valid/ready handshake with a registered result.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e      r_state;
  alu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;

  alu_op_e         w_op;
  logic            w_accept;
  logic            w_special;
  logic [XLEN-1:0] w_fast_result;
  logic [SHW-1:0]  w_shamt;
  logic            w_sign_a;
  logic            w_sign_b;
  logic            w_md_start;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;
  logic            w_res_load;
  logic [XLEN-1:0] w_res_nxt;
  logic            w_ill_nxt;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready & ~flush;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign illegal   = r_illegal;
  assign w_shamt   = data2[SHW-1:0];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_op = ALU_ILLEGAL;
    case (opcode)
      OP_R: begin
        case (func7)
          F7_BASE: begin
            case (func3)
              F3_ADD:  w_op = ALU_ADD;
              F3_SLL:  w_op = ALU_SLL;
              F3_SLT:  w_op = ALU_SLT;
              F3_SLTU: w_op = ALU_SLTU;
              F3_XOR:  w_op = ALU_XOR;
              F3_SR:   w_op = ALU_SRL;
              F3_OR:   w_op = ALU_OR;
              default: w_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (func3 == F3_ADD)     w_op = ALU_SUB;
            else if (func3 == F3_SR) w_op = ALU_SRA;
          end
          F7_MULDIV: begin
            case (func3)
              F3_MUL:    w_op = ALU_MUL;
              F3_MULH:   w_op = ALU_MULH;
              F3_MULHSU: w_op = ALU_MULHSU;
              F3_MULHU:  w_op = ALU_MULHU;
              F3_DIV:    w_op = ALU_DIV;
              F3_DIVU:   w_op = ALU_DIVU;
              F3_REM:    w_op = ALU_REM;
              default:   w_op = ALU_REMU;
            endcase
          end
          default: w_op = ALU_ILLEGAL;
        endcase
      end
      OP_I: begin
        // func7 here is immediate bits; only bit 5 distinguishes SRAI from SRLI.
        case (func3)
          F3_ADD:  w_op = ALU_ADD;
          F3_SLL:  w_op = ALU_SLL;
          F3_SLT:  w_op = ALU_SLT;
          F3_SLTU: w_op = ALU_SLTU;
          F3_XOR:  w_op = ALU_XOR;
          F3_SR:   w_op = func7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:   w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end
      default: w_op = ALU_ILLEGAL;
    endcase
  end

  always_comb begin
    w_fast_result = '0;
    w_special     = 1'b0;
    case (w_op)
      ALU_ADD:  w_fast_result = data1 + data2;
      ALU_SUB:  w_fast_result = data1 - data2;
      ALU_SLL:  w_fast_result = data1 << w_shamt;
      ALU_SLT:  w_fast_result = {{(XLEN-1){1'b0}}, $signed(data1) < $signed(data2)};
      ALU_SLTU: w_fast_result = {{(XLEN-1){1'b0}}, data1 < data2};
      ALU_XOR:  w_fast_result = data1 ^ data2;
      ALU_SRL:  w_fast_result = data1 >> w_shamt;
      ALU_SRA:  w_fast_result = $unsigned($signed(data1) >>> w_shamt);
      ALU_OR:   w_fast_result = data1 | data2;
      ALU_AND:  w_fast_result = data1 & data2;
      ALU_DIV, ALU_DIVU: begin
        if (data2 == '0) begin
          w_fast_result = '1;
          w_special     = 1'b1;
        end else if ((w_op == ALU_DIV) && (data1 == SMIN) && (data2 == '1)) begin
          w_fast_result = data1;
          w_special     = 1'b1;
        end
      end
      ALU_REM, ALU_REMU: begin
        if (data2 == '0) begin
          w_fast_result = data1;
          w_special     = 1'b1;
        end else if ((w_op == ALU_REM) && (data1 == SMIN) && (data2 == '1)) begin
          w_fast_result = '0;
          w_special     = 1'b1;
        end
      end
      default: w_fast_result = '0;
    endcase
  end

  assign w_sign_a = (w_op == ALU_MULH) | (w_op == ALU_MULHSU) |
                    (w_op == ALU_DIV)  | (w_op == ALU_REM);
  assign w_sign_b = (w_op == ALU_MULH) | (w_op == ALU_DIV) | (w_op == ALU_REM);

  always_comb begin
    w_state_nxt = r_state;
    w_md_start  = 1'b0;
    w_res_load  = 1'b0;
    w_res_nxt   = w_fast_result;
    w_ill_nxt   = (w_op == ALU_ILLEGAL);
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (w_md_done) begin
            w_state_nxt = S_DONE;
            w_res_load  = 1'b1;
            w_res_nxt   = w_md_result;
            w_ill_nxt   = 1'b0;
          end
        end
        default: begin
          if ((r_state == S_DONE) && out_ready) w_state_nxt = S_IDLE;
          if (w_accept) begin
            if (is_muldiv(w_op) && !w_special) begin
              w_state_nxt = S_BUSY;
              w_md_start  = 1'b1;
            end else begin
              w_state_nxt = S_DONE;
              w_res_load  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_res_load) begin
        r_result  <= w_res_nxt;
        r_illegal <= w_ill_nxt;
      end
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_md_start),
    .i_abort    (flush),
    .i_signed_a (w_sign_a),
    .i_signed_b (w_sign_b),
    .i_op       (w_op),
    .i_a        (data1),
    .i_b        (data2),
    .o_done     (w_md_done),
    .o_result   (w_md_result)
  );

endmodule
